mem_wb_skid: RTL and testbench

Parametrised MEM/WB pipeline boundary with a valid/ready handshake, replacing the fixed stall-vector register. It carries the write-back triple (write enable, destination register, write data) from the memory stage to the write-back stage. It absorbs one cycle of downstream back-pressure in a skid entry so that the upstream ready is registered. It also supports a synchronous flush and counts back-pressure cycles for performance monitoring.

---
 rtl/mem_wb_skid.sv | 108 ++++++++++
 tb/tb_mem_wb_skid.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline boundary: valid/ready handshake carrying the write-back triple,
// with an optional skid entry (registered in_ready), synchronous flush and a back-pressure counter.
module mem_wb_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_wd,
    output logic [DATA_W-1:0] out_wdata,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cnt
);

    typedef struct packed {
        logic              vld;
        logic              we;
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_ent;
    logic [CNT_W-1:0] bp_q, bp_d;
    logic             accept;
    logic             drain;

    assign in_ent = {1'b1, in_we, in_wd, in_wdata};

    // With a skid entry, in_ready depends only on held state and never on out_ready.
    assign in_ready = (SKID != 0) ? !skid_q.vld : (!main_q.vld || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = main_q.vld && out_ready;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = '0;
            skid_d = '0;
        end else if (SKID != 0) begin
            if (drain) begin
                if (skid_q.vld) begin
                    main_d = skid_q;
                    skid_d = '0;
                end else if (accept) begin
                    main_d = in_ent;
                end else begin
                    main_d = '0;
                end
            end else if (accept) begin
                if (!main_q.vld) begin
                    main_d = in_ent;
                end else begin
                    skid_d = in_ent;
                end
            end
        end else begin
            skid_d = '0;
            if (accept) begin
                main_d = in_ent;
            end else if (drain) begin
                main_d = '0;
            end
        end
    end

    // Stall cycles are counted even while flushing; the counter saturates.
    always_comb begin
        bp_d = bp_q;
        if (main_q.vld && !out_ready && (bp_q != '1)) begin
            bp_d = bp_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
            bp_q   <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            bp_q   <= bp_d;
        end
    end

    // Bubbles are masked so an empty slot can never cause a register-file write.
    assign out_valid = main_q.vld;
    assign out_we    = main_q.vld && main_q.we;
    assign out_wd    = main_q.vld ? main_q.wd : '0;
    assign out_wdata = main_q.vld ? main_q.wdata : '0;
    assign occupancy = 2'(main_q.vld) + 2'(skid_q.vld);
    assign bp_cnt    = bp_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: directed scenarios plus random traffic against a queue-based model.
module tb_mem_wb_skid;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_we, out_ready;
    logic [4:0]  in_wd;
    logic [31:0] in_wdata;

    logic        a_in_ready, a_out_valid, a_out_we;
    logic [4:0]  a_out_wd;
    logic [31:0] a_out_wdata;
    logic [1:0]  a_occ;
    logic [15:0] a_bp;

    logic        c_in_ready, c_out_valid, c_out_we;
    logic [4:0]  c_out_wd;
    logic [31:0] c_out_wdata;
    logic [1:0]  c_occ;
    logic [3:0]  c_bp;

    logic        z_in_ready, z_out_valid, z_out_we;
    logic [4:0]  z_out_wd;
    logic [31:0] z_out_wdata;
    logic [1:0]  z_occ;
    logic [15:0] z_bp;

    mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_we(in_we), .in_wd(in_wd), .in_wdata(in_wdata), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_we(a_out_we), .out_wd(a_out_wd), .out_wdata(a_out_wdata),
        .occupancy(a_occ), .bp_cnt(a_bp));

    mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .SKID(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_we(in_we), .in_wd(in_wd), .in_wdata(in_wdata), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_we(c_out_we), .out_wd(c_out_wd), .out_wdata(c_out_wdata),
        .occupancy(c_occ), .bp_cnt(c_bp));

    mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .SKID(0), .CNT_W(16)) dut_z (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_we(in_we), .in_wd(in_wd), .in_wdata(in_wdata), .out_valid(z_out_valid),
        .out_ready(out_ready), .out_we(z_out_we), .out_wd(z_out_wd), .out_wdata(z_out_wdata),
        .occupancy(z_occ), .bp_cnt(z_bp));

    wire [38:0] a_vec = {a_out_valid, a_out_we, a_out_wd, a_out_wdata};
    wire [38:0] c_vec = {c_out_valid, c_out_we, c_out_wd, c_out_wdata};
    wire [38:0] z_vec = {z_out_valid, z_out_we, z_out_wd, z_out_wdata};

    typedef struct packed {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdata;
    } ent_t;

    // Reference: a FIFO of capacity 2 (SKID=1) plus saturating stall counters.
    ent_t q[$];
    int   m_bp16, m_bp4;
    logic exp_rdy, obs_rdy;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [38:0] exp_vec();
        if (q.size() == 0) return 39'd0;
        return {1'b1, q[0]};
    endfunction

    task automatic step(input logic v, input logic we, input logic [4:0] wd,
                        input logic [31:0] wdata, input logic ordy, input logic fl);
        logic acc, drn, bpi;
        ent_t e;
        in_valid = v; in_we = we; in_wd = wd; in_wdata = wdata; out_ready = ordy; flush = fl;
        #3;
        obs_rdy = a_in_ready;
        exp_rdy = (q.size() < 2);
        acc = v && exp_rdy;
        drn = (q.size() > 0) && ordy && !fl;
        bpi = (q.size() > 0) && !ordy;
        e = '{we: we, wd: wd, wdata: wdata};
        @(posedge clk);
        if (bpi) begin
            if (m_bp16 < 65535) m_bp16++;
            if (m_bp4 < 15) m_bp4++;
        end
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; flush = 0; out_ready = 0; in_we = 0; in_wd = 0; in_wdata = 0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        q.delete(); m_bp16 = 0; m_bp4 = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        if (a_vec !== 39'd0) begin errors++; $display("FAIL reset_out: got %h expected 0", a_vec); end
        checks++;
        if ({a_in_ready, a_occ, a_bp} !== {1'b1, 2'd0, 16'd0}) begin
            errors++; $display("FAIL reset_ctl: got rdy=%b occ=%0d bp=%0d expected rdy=1 occ=0 bp=0", a_in_ready, a_occ, a_bp);
        end
        checks++;
        step(1, 1, 5'd9, 32'h1234, 0, 0);
        step(1, 1, 5'd10, 32'h5678, 0, 0);
        step(0, 0, 5'd0, 32'h0, 0, 0);
        if ({a_occ, a_bp} !== {2'(q.size()), 16'(m_bp16)}) begin
            errors++; $display("FAIL pre_reset: got occ=%0d bp=%0d expected occ=%0d bp=%0d", a_occ, a_bp, q.size(), m_bp16);
        end
        checks++;
        rst = 1'b0;
        #1;
        if ({a_vec, a_occ, a_bp, c_bp} !== 61'd0) begin
            errors++; $display("FAIL async_reset: got vec=%h occ=%0d bp=%0d bp4=%0d expected all 0", a_vec, a_occ, a_bp, c_bp);
        end
        checks++;
        if ({a_in_ready, z_in_ready} !== 2'b11) begin
            errors++; $display("FAIL async_reset_rdy: got %b expected 11", {a_in_ready, z_in_ready});
        end
        checks++;
        #1;
        rst = 1'b1;
        q.delete(); m_bp16 = 0; m_bp4 = 0;
        @(posedge clk);
        #1;
        if (a_vec !== 39'd0) begin errors++; $display("FAIL post_reset_lost: got %h expected 0", a_vec); end
        checks++;
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 5'(i + 1), 32'hA0 + i, 1, 0);
            if (a_vec !== {1'b1, 1'b1, 5'(i + 1), 32'hA0 + i}) begin
                errors++; $display("FAIL stream_out%0d: got %h expected %h", i, a_vec, {1'b1, 1'b1, 5'(i + 1), 32'hA0 + i});
            end
            checks++;
            if ({a_occ, a_bp} !== {2'd1, 16'd0}) begin
                errors++; $display("FAIL stream_occ%0d: got occ=%0d bp=%0d expected occ=1 bp=0", i, a_occ, a_bp);
            end
            checks++;
        end
        step(0, 0, 5'd0, 32'h0, 1, 0);
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", a_out_valid); end
        checks++;
    endtask

    task automatic test_skid_fill();
        do_reset();
        step(1, 1, 5'd5, 32'h55, 0, 0);
        if ({a_out_wd, a_in_ready} !== {5'd5, 1'b1}) begin
            errors++; $display("FAIL skid_first: got wd=%0d rdy=%b expected wd=5 rdy=1", a_out_wd, a_in_ready);
        end
        checks++;
        step(1, 1, 5'd6, 32'h66, 0, 0);
        if ({a_occ, a_in_ready, a_out_wd} !== {2'd2, 1'b0, 5'd5}) begin
            errors++; $display("FAIL skid_full: got occ=%0d rdy=%b wd=%0d expected occ=2 rdy=0 wd=5", a_occ, a_in_ready, a_out_wd);
        end
        checks++;
        step(0, 0, 5'd0, 32'h0, 0, 0);
        if ({a_occ, a_out_wd, a_out_wdata} !== {2'd2, 5'd5, 32'h55}) begin
            errors++; $display("FAIL skid_hold: got occ=%0d wd=%0d data=%h expected occ=2 wd=5 data=55", a_occ, a_out_wd, a_out_wdata);
        end
        checks++;
        step(0, 0, 5'd0, 32'h0, 1, 0);
        if ({a_out_wd, a_out_wdata, a_in_ready, a_occ} !== {5'd6, 32'h66, 1'b1, 2'd1}) begin
            errors++; $display("FAIL skid_drain: got wd=%0d data=%h rdy=%b occ=%0d expected wd=6 data=66 rdy=1 occ=1", a_out_wd, a_out_wdata, a_in_ready, a_occ);
        end
        checks++;
        step(0, 0, 5'd0, 32'h0, 1, 0);
        if (a_vec !== 39'd0) begin errors++; $display("FAIL skid_empty: got %h expected 0", a_vec); end
        checks++;
    endtask

    task automatic test_flush();
        int bp_before;
        do_reset();
        step(1, 1, 5'd8, 32'h88, 0, 0);
        step(1, 1, 5'd9, 32'h99, 0, 0);
        step(1, 1, 5'd7, 32'h77, 1, 1);
        if ({a_vec, a_occ} !== 41'd0) begin
            errors++; $display("FAIL flush_full: got vec=%h occ=%0d expected 0", a_vec, a_occ);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 5'd0, 32'h0, 1, 0);
            if (a_vec !== 39'd0) begin errors++; $display("FAIL flush_no7_%0d: got %h expected 0", i, a_vec); end
            checks++;
        end
        step(1, 1, 5'd11, 32'hBB, 0, 0);
        bp_before = m_bp16;
        step(1, 1, 5'd7, 32'h77, 0, 1);
        if (obs_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy: got %b expected 1", obs_rdy); end
        checks++;
        if ({a_vec, a_occ, a_bp} !== {41'd0, 16'(bp_before + 1)}) begin
            errors++; $display("FAIL flush_one: got vec=%h occ=%0d bp=%0d expected vec=0 occ=0 bp=%0d", a_vec, a_occ, a_bp, bp_before + 1);
        end
        checks++;
        step(0, 0, 5'd0, 32'h0, 1, 0);
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b expected 0", a_out_valid); end
        checks++;
    endtask

    task automatic test_bubble();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'h1f, 32'hFFFFFFFF, 1'(i % 2), 0);
            if (a_vec !== 39'd0) begin errors++; $display("FAIL bubble%0d: got %h expected 0", i, a_vec); end
            checks++;
        end
    endtask

    task automatic test_counter();
        do_reset();
        step(1, 1, 5'd3, 32'h33, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 5'd0, 32'h0, 0, 0);
            if (c_bp !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                errors++; $display("FAIL bp_sat%0d: got %0d expected %0d", i, c_bp, (i + 1 > 15) ? 15 : i + 1);
            end
            checks++;
        end
        if (a_bp !== 16'd20) begin errors++; $display("FAIL bp_wide: got %0d expected 20", a_bp); end
        checks++;
        rst = 1'b0;
        #1;
        if ({c_bp, a_bp} !== 20'd0) begin
            errors++; $display("FAIL bp_reset: got bp4=%0d bp=%0d expected 0", c_bp, a_bp);
        end
        checks++;
        #1;
        rst = 1'b1;
        q.delete(); m_bp16 = 0; m_bp4 = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_skid0();
        do_reset();
        in_valid = 1; in_we = 1; in_wd = 5'd12; in_wdata = 32'hC0; out_ready = 0; flush = 0;
        #1;
        if (z_in_ready !== 1'b1) begin errors++; $display("FAIL s0_empty_rdy: got %b expected 1", z_in_ready); end
        checks++;
        @(posedge clk);
        #1;
        if (z_vec !== {1'b1, 1'b1, 5'd12, 32'hC0}) begin
            errors++; $display("FAIL s0_load: got %h expected %h", z_vec, {1'b1, 1'b1, 5'd12, 32'hC0});
        end
        checks++;
        in_wd = 5'd13; in_wdata = 32'hC1; out_ready = 0;
        #1;
        if (z_in_ready !== 1'b0) begin errors++; $display("FAIL s0_stall_rdy: got %b expected 0", z_in_ready); end
        checks++;
        out_ready = 1;
        #1;
        if (z_in_ready !== 1'b1) begin errors++; $display("FAIL s0_pass_rdy: got %b expected 1", z_in_ready); end
        checks++;
        @(posedge clk);
        #1;
        if ({z_vec, z_occ, z_bp} !== {1'b1, 1'b1, 5'd13, 32'hC1, 2'd1, 16'd0}) begin
            errors++; $display("FAIL s0_swap: got vec=%h occ=%0d bp=%0d expected vec=%h occ=1 bp=0", z_vec, z_occ, z_bp, {1'b1, 1'b1, 5'd13, 32'hC1});
        end
        checks++;
        in_valid = 0;
        @(posedge clk);
        #1;
        if ({z_vec, z_occ} !== 41'd0) begin
            errors++; $display("FAIL s0_drain: got vec=%h occ=%0d expected 0", z_vec, z_occ);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [100:0] act, exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom), 5'($urandom), $urandom,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            act = {obs_rdy, a_vec, a_occ, a_bp, c_vec, c_bp};
            exp = {exp_rdy, exp_vec(), 2'(q.size()), 16'(m_bp16), exp_vec(), 4'(m_bp4)};
            if (act !== exp) begin
                errors++; $display("FAIL random%0d: got %h expected %h", i, act, exp);
            end
            checks++;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 0; in_valid = 0; in_we = 0; in_wd = 0; in_wdata = 0; out_ready = 0;
        #1;
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush();
        test_bubble();
        test_counter();
        test_random();
        test_skid0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
